psum_drain: RTL and testbench

//  Reader side of the systolic array's bottom edge. Captures the skewed partial_sum_out of the last PE row
//  (column j lags column j-1 by one cycle) and de-skews it into whole result rows.

---
 rtl/utpu_pkg.sv | 16 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/psum_drain.sv | 155 +++++++++++++++
 tb/tb_psum_drain.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/utpu_pkg.sv
// Shared types for the systolic-array support blocks: accumulator element
// type and the result-drain FSM states.
package utpu_pkg;

  localparam int ACCUMULATOR_DATA_WIDTH = 16;

  typedef logic signed [ACCUMULATOR_DATA_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DRAIN
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; the head entry is read straight from the storage registers,
// so a push into an empty FIFO becomes visible on the following cycle.
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/psum_drain.sv
// De-skews the bottom PE row's partial sums into whole rows and streams them out
// through a FIFO. Define PSUM_DRAIN_RELU_EN to clamp negative elements to zero.
module psum_drain #(
  parameter int ARRAY_DIM              = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int PIPE_LAT               = 4,
  parameter int MAX_ROWS               = 16,
  parameter int FIFO_DEPTH             = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]               m_rows,
  input  logic [ARRAY_DIM*ACCUMULATOR_DATA_WIDTH-1:0] psum_in,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [ARRAY_DIM*ACCUMULATOR_DATA_WIDTH-1:0] out_row,
  output logic                                        out_last,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        overflow
);

  import utpu_pkg::*;

  localparam int ACC_W    = ACCUMULATOR_DATA_WIDTH;
  localparam int ROW_W    = $clog2(MAX_ROWS + 1);
  localparam int ROW_BITS = ARRAY_DIM * ACC_W;
  // The start cycle itself counts toward the pipeline wait.
  localparam int WAIT_CYC = PIPE_LAT + ARRAY_DIM - 2;
  localparam int WCNT_W   = $clog2(WAIT_CYC + 1);

  drain_state_e      state_reg, state_next;
  logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [ROW_W-1:0]  rows_reg, rows_next;
  logic [ROW_W-1:0]  row_idx_reg, row_idx_next;
  logic              overflow_reg;
  logic [ROW_BITS-1:0] aligned;
  logic              push, push_last, pop;
  logic              fifo_full, fifo_empty;
  logic [ROW_BITS:0] fifo_head;

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_DIM; gi++) begin : g_col
      localparam int STAGES = ARRAY_DIM - 1 - gi;
      if (STAGES == 0) begin : g_pass
        assign aligned[gi*ACC_W +: ACC_W] = psum_in[gi*ACC_W +: ACC_W];
      end else begin : g_dly
        logic [ACC_W-1:0] dly_reg [STAGES];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int k = 0; k < STAGES; k++) dly_reg[k] <= '0;
          end else begin
            dly_reg[0] <= psum_in[gi*ACC_W +: ACC_W];
            for (int k = 1; k < STAGES; k++) dly_reg[k] <= dly_reg[k-1];
          end
        end
        assign aligned[gi*ACC_W +: ACC_W] = dly_reg[STAGES-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      rows_reg     <= '0;
      row_idx_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      rows_reg     <= rows_next;
      row_idx_reg  <= row_idx_next;
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    rows_next     = rows_reg;
    row_idx_next  = row_idx_reg;
    push          = 1'b0;
    push_last     = 1'b0;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (m_rows != '0)) begin
          state_next    = WAIT;
          rows_next     = m_rows;
          wait_cnt_next = WCNT_W'(WAIT_CYC - 1);
        end
      end
      WAIT: begin
        if (wait_cnt_reg == '0) begin
          state_next   = CAPTURE;
          row_idx_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg - WCNT_W'(1);
        end
      end
      CAPTURE: begin
        push      = 1'b1;
        push_last = (row_idx_reg == rows_reg - ROW_W'(1));
        if (push_last) state_next = DRAIN;
        else           row_idx_next = row_idx_reg + ROW_W'(1);
      end
      DRAIN: begin
        // An empty FIFO without a tagged pop means the last row was dropped.
        if (pop && fifo_head[ROW_BITS]) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (fifo_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH(ROW_BITS + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({push_last, aligned}),
    .pop      (pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && fifo_head[ROW_BITS];
  assign busy      = (state_reg != IDLE);
  assign overflow  = overflow_reg;

  generate
    for (gi = 0; gi < ARRAY_DIM; gi++) begin : g_out
      logic [ACC_W-1:0] elem;
      assign elem = fifo_head[gi*ACC_W +: ACC_W];
`ifdef PSUM_DRAIN_RELU_EN
      assign out_row[gi*ACC_W +: ACC_W] = (out_valid && !elem[ACC_W-1]) ? elem : '0;
`else
      assign out_row[gi*ACC_W +: ACC_W] = out_valid ? elem : '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_psum_drain.sv
// Randomized self-checking bench for psum_drain: skewed matrices are fed per the
// array timing and compared cycle by cycle against a queue-based reference model.
module tb_psum_drain;

  localparam int D     = 4;
  localparam int W     = 16;
  localparam int P     = 4;
  localparam int MAXR  = 16;
  localparam int DEPTH = 8;
  localparam int RB    = D * W;
  localparam int RW    = $clog2(MAXR + 1);

  logic          clk = 1'b0;
  logic          rst, start, out_valid, out_ready, out_last, busy, done, overflow;
  logic [RW-1:0] m_rows;
  logic [RB-1:0] psum_in, out_row;

  always #5 clk = ~clk;

  psum_drain #(
    .ARRAY_DIM(D), .ACCUMULATOR_DATA_WIDTH(W), .PIPE_LAT(P),
    .MAX_ROWS(MAXR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .m_rows(m_rows), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct packed {
    logic          last;
    logic [RB-1:0] row;
  } ent_t;

  // Reference model: job window by cycle number plus a bounded row queue.
  ent_t          q[$];
  logic [RB-1:0] mat [MAXR];
  bit            m_busy, m_ovf;
  int            t0, mr, cyc;
  int            tests, fails;
  bit            drv_rst, drv_start, drv_ready;
  int            drv_m, ready_mode;
  bit            prev_stall;
  logic [RB-1:0] prev_row, last_pop_row;
  int            pops, dones;

  task automatic check(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [RB-1:0] expect_row(input logic [RB-1:0] r);
    logic [RB-1:0] o;
    o = r;
`ifdef PSUM_DRAIN_RELU_EN
    for (int j = 0; j < D; j++)
      if (r[j*W+W-1]) o[j*W +: W] = '0;
`endif
    return o;
  endfunction

  task automatic tick();
    int   idx;
    bit   pop, exp_done, was_empty, push;
    ent_t e;
    @(negedge clk);
    if (ready_mode == 1) drv_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) drv_ready = !drv_ready;
    rst       = drv_rst;
    start     = drv_start;
    m_rows    = RW'(drv_m);
    out_ready = drv_ready;
    for (int j = 0; j < D; j++) begin
      idx = cyc - t0 - P - j;
      if (m_busy && idx >= 0 && idx < mr) psum_in[j*W +: W] = mat[idx][j*W +: W];
      else                                psum_in[j*W +: W] = W'($urandom);
    end
    #1;
    was_empty = (q.size() == 0);
    pop       = !was_empty && drv_ready;
    exp_done  = pop && q[0].last;
    if (!drv_rst) begin
      check("busy", RB'(busy), RB'(m_busy));
      check("out_valid", RB'(out_valid), RB'(!was_empty));
      check("done", RB'(done), RB'(exp_done));
      check("overflow", RB'(overflow), RB'(m_ovf));
      if (!was_empty) begin
        check("out_row", out_row, expect_row(q[0].row));
        check("out_last", RB'(out_last), RB'(q[0].last));
      end
      if (prev_stall) check("stable", out_row, prev_row);
      if (done) dones++;
      if (out_valid && out_ready) begin
        pops++;
        last_pop_row = out_row;
        $display("[TB] cyc %0d pop row=%h last=%0b", cyc, out_row, out_last);
      end
    end
    prev_stall = !drv_rst && out_valid && !out_ready;
    prev_row   = out_row;
    if (drv_rst) begin
      q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      mr     = 0;
    end else begin
      idx  = cyc - (t0 + P + D - 1);
      push = m_busy && idx >= 0 && idx < mr;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin
          e.last = (idx == mr - 1);
          e.row  = mat[idx];
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (!m_busy) begin
        if (drv_start && drv_m != 0) begin
          m_busy = 1'b1;
          t0     = cyc;
          mr     = drv_m;
        end
      end else if (idx >= mr && (exp_done || was_empty)) begin
        m_busy = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic start_job(input int m);
    drv_start = 1'b1;
    drv_m     = m;
    tick();
    drv_start = 1'b0;
    drv_m     = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    check("idle_busy", RB'(busy), RB'(0));
    check("idle_valid", RB'(out_valid), RB'(0));
  endtask

  task automatic fill_random(input int m);
    for (int i = 0; i < m; i++) mat[i] = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; t0 = 0; mr = 0;
    m_busy = 0; m_ovf = 0; prev_stall = 0; pops = 0; dones = 0;
    drv_rst = 1; drv_start = 0; drv_m = 0; drv_ready = 1; ready_mode = 0;
    repeat (3) tick();
    drv_rst = 0;
    tick();
    check("rst_out_row", out_row, RB'(0));
    check("rst_out_last", RB'(out_last), RB'(0));

    // Basic two-row matrix with an always-ready consumer.
    mat[0] = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
    mat[1] = {16'sd8, -16'sd7, 16'sd6, -16'sd5};
    pops = 0; dones = 0;
    start_job(2);
    wait_idle(100);
    check("basic_pops", RB'(pops), RB'(2));
    check("basic_dones", RB'(dones), RB'(1));

    // Random jobs with random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 5; r++) begin
      int m;
      m = $urandom_range(1, 8);
      fill_random(m);
      pops = 0;
      start_job(m);
      wait_idle(200);
      check("rand_pops", RB'(pops), RB'(m));
    end

    // Backpressure: stalled through capture, then toggling ready.
    ready_mode = 0; drv_ready = 0;
    fill_random(8);
    pops = 0; dones = 0;
    start_job(8);
    repeat (16) tick();
    ready_mode = 2;
    wait_idle(200);
    check("bp_pops", RB'(pops), RB'(8));
    check("bp_dones", RB'(dones), RB'(1));
    check("bp_overflow", RB'(overflow), RB'(0));

    // Overflow: ten rows into an eight-deep FIFO with no consumer.
    ready_mode = 0; drv_ready = 0;
    fill_random(10);
    pops = 0; dones = 0;
    start_job(10);
    repeat (20) tick();
    check("ovf_flag", RB'(overflow), RB'(1));
    ready_mode = 1;
    wait_idle(200);
    check("ovf_pops", RB'(pops), RB'(8));
    check("ovf_dones", RB'(dones), RB'(0));

    // Ignored starts: zero rows, and a second start during the wait.
    ready_mode = 0; drv_ready = 1;
    start_job(0);
    tick();
    check("zero_rows_busy", RB'(busy), RB'(0));
    fill_random(3);
    pops = 0;
    start_job(3);
    tick();
    start_job(5);
    wait_idle(200);
    check("wait_start_pops", RB'(pops), RB'(3));

    // Reset in the middle of capture.
    fill_random(6);
    start_job(6);
    repeat (P + D) tick();
    drv_rst = 1;
    tick();
    tick();
    drv_rst = 0;
    tick();
    check("rst_mid_busy", RB'(busy), RB'(0));
    check("rst_mid_valid", RB'(out_valid), RB'(0));
    check("rst_mid_overflow", RB'(overflow), RB'(0));
    fill_random(4);
    pops = 0;
    start_job(4);
    wait_idle(200);
    check("post_rst_pops", RB'(pops), RB'(4));

    // Clamp row: col0=-3, col1=0, col2=7, col3=-32768.
    mat[0] = {16'sh8000, 16'sd7, 16'sd0, -16'sd3};
    start_job(1);
    wait_idle(100);
`ifdef PSUM_DRAIN_RELU_EN
    check("relu_row", last_pop_row, 64'h0000_0007_0000_0000);
`else
    check("relu_row", last_pop_row, 64'h8000_0007_0000_fffd);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
